// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
//  Module   : serializer
//  Purpose  : Transmit end of the 2-phase serial link. Captures packets over a
//             toggle req/ack handshake and shifts them out LSB first in
//             free-running FRAME_BITS-cycle slots, filling empty slots with
//             IDLE_WORD.
//  Revision : 1.0  initial release
// ============================================================================
module serializer #(
    parameter int                    FRAME_BITS = 32,
    parameter logic [FRAME_BITS-1:0] IDLE_WORD  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [FRAME_BITS-1:0] data_in,
    output logic                  ack,
    output logic                  dout,
    output logic                  frame_start,
    output logic                  underrun
);

    typedef struct packed {
        logic [7:0] head;
        logic [7:0] dst;
        logic [7:0] pay;
        logic [7:0] crc;
    } packet_in_t;

    localparam int                c_CNT_W = $clog2(FRAME_BITS);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] r_shreg;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    packet_in_t            r_hold;
    logic                  r_hold_vld;
    logic                  r_ack;
    logic                  r_idle_slot;

    logic w_load_now;
    logic w_pending;
    logic w_capture;

    assign w_load_now = (r_bit_cnt == c_LAST);
    assign w_pending  = req ^ r_ack;
    // A full hold register frees up exactly at the slot boundary, so a
    // waiting packet may be taken on that same edge.
    assign w_capture  = w_pending && (!r_hold_vld || w_load_now);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shreg     <= IDLE_WORD;
            r_bit_cnt   <= '0;
            r_hold      <= '0;
            r_hold_vld  <= 1'b0;
            r_ack       <= 1'b0;
            r_idle_slot <= 1'b1;
        end else begin
            // Slot loads only from hold as it stood before this edge: a packet
            // captured on the boundary waits for the next slot.
            if (w_load_now) begin
                r_shreg     <= r_hold_vld ? FRAME_BITS'(r_hold) : IDLE_WORD;
                r_bit_cnt   <= '0;
                r_idle_slot <= !r_hold_vld;
            end else begin
                r_shreg     <= {1'b0, r_shreg[FRAME_BITS-1:1]};
                r_bit_cnt   <= r_bit_cnt + c_CNT_W'(1);
            end

            if (w_capture) begin
                r_hold     <= packet_in_t'(data_in);
                r_hold_vld <= 1'b1;
                r_ack      <= ~r_ack;
            end else if (w_load_now) begin
                r_hold_vld <= 1'b0;
            end
        end
    end

    assign ack         = r_ack;
    assign dout        = r_shreg[0];
    assign frame_start = (r_bit_cnt == '0);
    assign underrun    = r_idle_slot && (r_bit_cnt == '0);

endmodule
`default_nettype wire

// File: tb/tb_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serializer
//  Purpose  : Self-checking bench for serializer: slot-level reference model,
//             loopback deserializer and directed/random handshake scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serializer;

    localparam logic [31:0] c_IDLE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] data_in = '0;
    logic        ack;
    logic        dout;
    logic        frame_start;
    logic        underrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serializer #(
        .FRAME_BITS (32),
        .IDLE_WORD  (c_IDLE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .data_in     (data_in),
        .ack         (ack),
        .dout        (dout),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    // Reference model: t is the cycle index since reset, the slot position is
    // t mod 32, and the word on the line is addressed by position.
    bit          model_valid = 1'b0;
    int          t = 0;
    logic [31:0] m_word = c_IDLE;
    bit          m_under = 1'b1;
    bit          m_ack = 1'b0;
    logic [31:0] hold_q[$];
    logic [31:0] exp_q[$];

    always @(posedge clk) begin
        if (rst) begin
            t = 0;
            m_word = c_IDLE;
            m_under = 1'b1;
            m_ack = 1'b0;
            hold_q.delete();
            exp_q.delete();
            model_valid = 1'b1;
        end else if (model_valid) begin
            bit boundary;
            bit take;
            boundary = ((t % 32) == 31);
            take = (req != m_ack) && (hold_q.size() == 0 || boundary);
            if (boundary) begin
                if (hold_q.size() != 0) begin
                    m_word = hold_q.pop_front();
                    m_under = 1'b0;
                    exp_q.push_back(m_word);
                end else begin
                    m_word = c_IDLE;
                    m_under = 1'b1;
                end
            end
            if (take) begin
                hold_q.push_back(data_in);
                m_ack = !m_ack;
            end
            t = t + 1;
        end
    end

    // Cycle-by-cycle scoreboard plus loopback deserializer.
    logic [31:0] rx_word = '0;
    int          rx_idx = 0;
    bit          rx_on = 1'b0;
    bit          rx_data = 1'b0;

    always @(negedge clk) begin
        if (model_valid) begin
            int pos;
            logic [31:0] w;
            pos = t % 32;
            n_cmp++;
            if (dout !== m_word[pos]) begin
                n_err++;
                $display("FAIL sb_dout t=%0d got %b want %b", t, dout, m_word[pos]);
            end
            n_cmp++;
            if (frame_start !== (pos == 0)) begin
                n_err++;
                $display("FAIL sb_frame_start t=%0d got %b want %b", t, frame_start, (pos == 0));
            end
            n_cmp++;
            if (underrun !== ((pos == 0) && m_under)) begin
                n_err++;
                $display("FAIL sb_underrun t=%0d got %b want %b", t, underrun, ((pos == 0) && m_under));
            end
            n_cmp++;
            if (ack !== m_ack) begin
                n_err++;
                $display("FAIL sb_ack t=%0d got %b want %b", t, ack, m_ack);
            end

            if (frame_start === 1'b1) begin
                rx_idx = 0;
                rx_on = 1'b1;
                rx_data = (underrun !== 1'b1);
            end
            if (rx_on) begin
                rx_word[rx_idx] = dout;
                rx_idx++;
                if (rx_idx == 32) begin
                    rx_on = 1'b0;
                    if (rx_data) begin
                        n_cmp++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL rx_unexpected t=%0d got %h want none", t, rx_word);
                        end else begin
                            w = exp_q.pop_front();
                            if (rx_word !== w) begin
                                n_err++;
                                $display("FAIL rx_word t=%0d got %h want %h", t, rx_word, w);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 1'b0;
        data_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic goto_cycle(input int c);
        while (t < c) @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] w);
        data_in = w;
        req = ~req;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 96; i++) begin
            n_cmp++;
            if (dout !== 1'b0 || ack !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle i=%0d got dout=%b ack=%b want 0/0", i, dout, ack);
            end
            n_cmp++;
            if (frame_start !== ((i % 32) == 0) || underrun !== ((i % 32) == 0)) begin
                n_err++;
                $display("FAIL reset_frame i=%0d got fs=%b ur=%b want %b", i, frame_start, underrun, ((i % 32) == 0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        logic [31:0] got;
        do_reset();
        goto_cycle(5);
        n_cmp++;
        if (ack !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack_pre got %b want 0", ack);
        end
        offer(32'hA53C_0F81);
        @(negedge clk);
        n_cmp++;
        if (ack !== 1'b1 || t != 6) begin
            n_err++;
            $display("FAIL single_ack t=%0d got %b want 1 at t=6", t, ack);
        end
        goto_cycle(32);
        n_cmp++;
        if (underrun !== 1'b0 || frame_start !== 1'b1) begin
            n_err++;
            $display("FAIL single_slot1_start got ur=%b fs=%b want 0/1", underrun, frame_start);
        end
        for (int i = 0; i < 32; i++) begin
            got[i] = dout;
            @(negedge clk);
        end
        n_cmp++;
        if (got !== 32'hA53C_0F81) begin
            n_err++;
            $display("FAIL single_word got %h want a53c0f81", got);
        end
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL single_slot2_underrun got %b want 1", underrun);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] words [3];
        int          want_cyc [3];
        words = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF};
        want_cyc = '{1, 32, 64};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            offer(words[k]);
            for (int j = 0; j < 64 && ack !== req; j++) @(negedge clk);
            n_cmp++;
            if (ack !== req || t != want_cyc[k] || underrun !== 1'b0) begin
                n_err++;
                $display("FAIL b2b_ack k=%0d got t=%0d ack=%b ur=%b want t=%0d ack=%b ur=0",
                         k, t, ack, underrun, want_cyc[k], req);
            end
        end
        goto_cycle(96);
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_slot3 got ur=%b want 0", underrun);
        end
        goto_cycle(128);
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_slot4 got ur=%b want 1", underrun);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        offer(32'h1234_5678);
        goto_cycle(31);
        offer(32'h9ABC_DEF0);
        @(negedge clk);
        n_cmp++;
        if (ack !== req || underrun !== 1'b0 || t != 32) begin
            n_err++;
            $display("FAIL simul_boundary t=%0d got ack=%b ur=%b want ack=%b ur=0", t, ack, underrun, req);
        end
        goto_cycle(64);
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL simul_slot2 got ur=%b want 0", underrun);
        end
        goto_cycle(96);
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL simul_slot3 got ur=%b want 1", underrun);
        end
    endtask

    task automatic test_load_empty();
        do_reset();
        goto_cycle(31);
        offer(32'hC0DE_0001);
        @(negedge clk);
        n_cmp++;
        if (ack !== req || underrun !== 1'b1) begin
            n_err++;
            $display("FAIL empty_boundary got ack=%b ur=%b want ack=%b ur=1", ack, underrun, req);
        end
        goto_cycle(64);
        n_cmp++;
        if (underrun !== 1'b0) begin
            n_err++;
            $display("FAIL empty_next_slot got ur=%b want 0", underrun);
        end
        goto_cycle(96);
    endtask

    task automatic test_reset_mid();
        do_reset();
        offer(32'h5555_AAAA);
        @(negedge clk);
        offer(32'hDEAD_BEEF);
        goto_cycle(49);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dout !== 1'b0 || ack !== 1'b0 || frame_start !== 1'b1 || underrun !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_state got dout=%b ack=%b fs=%b ur=%b want 0/0/1/1",
                     dout, ack, frame_start, underrun);
        end
        rst = 1'b0;
        goto_cycle(32);
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_slot1 got ur=%b want 1", underrun);
        end
        goto_cycle(64);
        n_cmp++;
        if (underrun !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_slot2 got ur=%b want 1", underrun);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 16; k++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            offer($urandom);
            for (int j = 0; j < 80 && ack !== req; j++) @(negedge clk);
            n_cmp++;
            if (ack !== req) begin
                n_err++;
                $display("FAIL rand_ack_timeout k=%0d got %b want %b", k, ack, req);
            end
        end
        repeat (100) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rand_drain got %0d words outstanding want 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_simultaneous();
        test_load_empty();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/serializer.md
Name: serializer

Overview:
- Transmit end of the 2-phase serial link. Accepts 32-bit packets (packet_in_t: head[31:24], dst[23:16], pay[15:8], crc[7:0]) from the upstream producer over a 2-phase (toggle) req/ack handshake.
- Shifts each packet out on a single serial line, LSB first (crc[0] first, head[7] last), in free-running 32-cycle frame slots.
- When no packet is available at a slot boundary, sends the idle word, so the far-end deserializer's free-running 32-bit framing stays aligned.

Parameters:
- FRAME_BITS, 32, bits per frame slot; must equal the packet_in_t width.
- IDLE_WORD, 32'h0000_0000, word transmitted in a slot with no pending packet.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  producer request; a toggle (req != ack) offers data_in.
- data_in  in  32  packet_in_t; held stable by the producer while req != ack.
- ack  out  1  acknowledge toggle; flips once per captured packet.
- dout  out  1  serial data, registered; LSB of the shift register.
- frame_start  out  1  high during the cycle dout carries bit 0 of a slot.
- underrun  out  1  one-cycle pulse, high during bit 0 of a slot that carries IDLE_WORD.

Behaviour:
- Reset values (registered on the cycle rst is sampled high):
  - shreg = IDLE_WORD, bit_cnt = 0, hold = 0, hold_vld = 0, ack = 0.
  - dout = IDLE_WORD[0], frame_start = 1, underrun = 1.
  - The first slot after reset is an idle slot and starts in the first cycle rst is low.
- Slot timing:
  - bit_cnt counts 0..FRAME_BITS-1, wraps to 0, and free-runs regardless of traffic.
  - dout = shreg[0].
  - When bit_cnt != 31, each edge performs shreg <= {1'b0, shreg[31:1]}.
  - frame_start = (bit_cnt == 0), registered-equivalent.
- Slot boundary (load_now = bit_cnt == 31):
  - At the edge, shreg <= hold_vld ? hold : IDLE_WORD and bit_cnt <= 0.
  - If hold_vld, hold_vld clears unless a capture happens in the same edge; see below.
  - underrun in the next bit 0 cycle = !hold_vld at that edge.
- Handshake:
  - pending = req ^ ack; req is already synchronous to clk.
  - capture = pending && (!hold_vld || load_now).
  - On capture: hold <= data_in, hold_vld <= 1, ack <= ~ack.
  - Capture at load_now with hold_vld=1: the old hold moves to shreg and the new packet enters hold in the same edge; hold_vld stays 1.
  - No bypass: a packet captured at the load_now edge with hold_vld=0 does not enter this slot. The slot sends IDLE_WORD and the packet goes out in the following slot.
  - Latency: ack toggles the edge after req toggles if hold is free. First bit on dout is at the next slot boundary (1..32 cycles after capture, plus 1).
  - Back-pressure: at most one packet in hold plus one in shreg. While hold_vld=1 and !load_now, ack does not toggle; the producer waits.
  - A req toggle while pending is a protocol violation; behaviour is undefined and is not checked.
- Reset mid-frame: the partial frame is abandoned, hold is discarded, and ack returns to 0. The producer must also reset (req=0) under the same rst.
- Throughput: 1 packet per 32 cycles sustained, with no idle slots as long as the producer re-toggles req within 31 cycles of each ack.

Test Plan:
- Reset then no req for 96 cycles -> dout constantly 0; frame_start high on cycles 0, 32, 64; underrun pulses with each frame_start; ack stays 0.
- Single packet {head=8'hA5, dst=8'h3C, pay=8'h0F, crc=8'h81} toggled at cycle 5:
  - ack toggles at cycle 6.
  - Slot 1 (cycles 32..63) emits 32'hA53C0F81 LSB first (1,0,0,0,0,0,0,1,...).
  - underrun is low at cycle 32 and high again at cycle 64.
- Back-to-back producer toggling req immediately after each ack with words 32'h00000001, 32'h80000000, 32'hFFFFFFFF:
  - The second ack is delayed until the load_now edge.
  - Three consecutive non-idle slots appear with no underrun between them.
- Simultaneous event: hold full and req toggled exactly at bit_cnt==31 -> the held word loads into shreg, the new word is captured, ack toggles on the same edge, and the next slot has no underrun.
- Capture at load_now with hold empty -> that slot is idle (underrun=1) and the packet appears in the following slot.
- Assert rst at bit 17 of a data slot with a packet in hold -> dout=0 and ack=0 after one edge; the held packet is never transmitted; slot timing restarts at bit 0. A loopback deserializer recovers every non-idle word bit-exact.
